// File: rtl/fan_pkg.sv
// Shared types and default constants for the fan PWM controller.
package fan_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_KICK = 2'd1,
        ST_RAMP = 2'd2,
        ST_HOLD = 2'd3
    } fan_state_e;

    localparam int DEF_NUM_CHANNELS = 2;
    localparam int DEF_DUTY_WIDTH   = 8;
    localparam int DEF_PRESCALE_DIV = 50;
    localparam int DEF_KICK_PERIODS = 4;
    localparam int DEF_TACH_WINDOW  = 256;
    localparam int TACH_CNT_W       = 16;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fan_pwm_chan.sv
// One fan channel: spin-up FSM, glitch-free duty register, PWM comparator and
// optional tach counter (present only when FAN_PWM_CTRL_TACH_EN is defined).
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_OFF  | fan stopped, cur_duty = 0
// ST_KICK | full duty for KickPeriods periods to break stiction
// ST_RAMP | cur_duty steps by one per period toward the sampled target
// ST_HOLD | cur_duty equals target, waiting for a new target
module fan_pwm_chan
    import fan_pkg::*;
#(
    parameter int DutyWidth   = DEF_DUTY_WIDTH,
    parameter int KickPeriods = DEF_KICK_PERIODS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DutyWidth-1:0]  pwm_cnt_i,
    input  logic                  period_end_i,
    input  logic                  win_end_i,
    input  logic [DutyWidth-1:0]  duty_i,
    input  logic                  tach_i,
    output logic                  fan_pwm_o,
    output logic                  busy_o,
    output logic [TACH_CNT_W-1:0] tach_cnt_o
);

    localparam int KickW = cnt_width(KickPeriods);
    localparam logic [DutyWidth-1:0] DutyMax = '1;

    fan_state_e           state_q, state_d;
    logic [DutyWidth-1:0] cur_duty_q, cur_duty_d;
    logic [KickW-1:0]     kick_cnt_q, kick_cnt_d;
    logic                 pwm_q, pwm_d;
    logic [DutyWidth-1:0] step;

    always_comb begin
        state_d    = state_q;
        cur_duty_d = cur_duty_q;
        kick_cnt_d = kick_cnt_q;
        step       = cur_duty_q;
        if (period_end_i) begin
            // A zero target wins over every other transition.
            if (duty_i == '0) begin
                state_d    = ST_OFF;
                cur_duty_d = '0;
                kick_cnt_d = '0;
            end else begin
                case (state_q)
                    ST_OFF: begin
                        state_d    = ST_KICK;
                        cur_duty_d = DutyMax;
                        kick_cnt_d = '0;
                    end
                    ST_KICK: begin
                        if (kick_cnt_q == KickW'(KickPeriods - 1)) begin
                            state_d = ST_RAMP;
                        end else begin
                            kick_cnt_d = kick_cnt_q + KickW'(1);
                        end
                    end
                    ST_RAMP: begin
                        if (cur_duty_q < duty_i) begin
                            step = cur_duty_q + DutyWidth'(1);
                        end else if (cur_duty_q > duty_i) begin
                            step = cur_duty_q - DutyWidth'(1);
                        end
                        cur_duty_d = step;
                        if (step == duty_i) begin
                            state_d = ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (duty_i != cur_duty_q) begin
                            state_d = ST_RAMP;
                        end
                    end
                    default: state_d = ST_OFF;
                endcase
            end
        end
        pwm_d = (pwm_cnt_i < cur_duty_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_OFF;
            cur_duty_q <= '0;
            kick_cnt_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_duty_q <= cur_duty_d;
            kick_cnt_q <= kick_cnt_d;
            pwm_q      <= pwm_d;
        end
    end

    assign fan_pwm_o = pwm_q;
    assign busy_o    = (state_q == ST_KICK) || (state_q == ST_RAMP);

`ifdef FAN_PWM_CTRL_TACH_EN
    // Bits [1:0] synchronise, bit 2 holds the previous synchronised level.
    logic [2:0]            tach_sync_q, tach_sync_d;
    logic [TACH_CNT_W-1:0] tach_acc_q, tach_acc_d;
    logic [TACH_CNT_W-1:0] tach_out_q, tach_out_d;
    logic                  tach_rise;

    always_comb begin
        tach_sync_d = {tach_sync_q[1:0], tach_i};
        tach_rise   = tach_sync_q[1] & ~tach_sync_q[2];
        tach_acc_d  = tach_acc_q;
        tach_out_d  = tach_out_q;
        if (win_end_i) begin
            tach_out_d = tach_acc_q;
            tach_acc_d = {{(TACH_CNT_W-1){1'b0}}, tach_rise};
        end else if (tach_rise && (tach_acc_q != '1)) begin
            tach_acc_d = tach_acc_q + TACH_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tach_sync_q <= '0;
            tach_acc_q  <= '0;
            tach_out_q  <= '0;
        end else begin
            tach_sync_q <= tach_sync_d;
            tach_acc_q  <= tach_acc_d;
            tach_out_q  <= tach_out_d;
        end
    end

    assign tach_cnt_o = tach_out_q;
`else
    logic tach_unused;
    assign tach_unused = tach_i ^ win_end_i;
    assign tach_cnt_o  = '0;
`endif

endmodule

// File: rtl/fan_pwm_ctrl.sv
// Multi-channel fan PWM controller: shared prescaler, PWM and tach-window
// counters feeding per-channel instances. Tach counting needs FAN_PWM_CTRL_TACH_EN.
module fan_pwm_ctrl
    import fan_pkg::*;
#(
    parameter int NumChannels = DEF_NUM_CHANNELS,
    parameter int DutyWidth   = DEF_DUTY_WIDTH,
    parameter int PrescaleDiv = DEF_PRESCALE_DIV,
    parameter int KickPeriods = DEF_KICK_PERIODS,
    parameter int TachWindow  = DEF_TACH_WINDOW
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumChannels*DutyWidth-1:0]  duty_i,
    input  logic [NumChannels-1:0]            tach_i,
    output logic [NumChannels-1:0]            fan_pwm_o,
    output logic [NumChannels-1:0]            busy_o,
    output logic [NumChannels*TACH_CNT_W-1:0] tach_cnt_o
);

    localparam int PresW = cnt_width(PrescaleDiv);

    logic [PresW-1:0]     presc_q, presc_d;
    logic [DutyWidth-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                 tick;
    logic                 period_end;
    logic                 win_end;

    always_comb begin
        tick       = (presc_q == PresW'(PrescaleDiv - 1));
        presc_d    = tick ? '0 : presc_q + PresW'(1);
        pwm_cnt_d  = tick ? pwm_cnt_q + DutyWidth'(1) : pwm_cnt_q;
        period_end = tick & (&pwm_cnt_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

`ifdef FAN_PWM_CTRL_TACH_EN
    localparam int WinW = cnt_width(TachWindow);

    logic [WinW-1:0] win_q, win_d;

    always_comb begin
        win_end = period_end && (win_q == WinW'(TachWindow - 1));
        win_d   = win_q;
        if (period_end) begin
            win_d = win_end ? '0 : win_q + WinW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end
`else
    assign win_end = 1'b0;
`endif

    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        fan_pwm_chan #(
            .DutyWidth   (DutyWidth),
            .KickPeriods (KickPeriods)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .pwm_cnt_i    (pwm_cnt_q),
            .period_end_i (period_end),
            .win_end_i    (win_end),
            .duty_i       (duty_i[c*DutyWidth +: DutyWidth]),
            .tach_i       (tach_i[c]),
            .fan_pwm_o    (fan_pwm_o[c]),
            .busy_o       (busy_o[c]),
            .tach_cnt_o   (tach_cnt_o[c*TACH_CNT_W +: TACH_CNT_W])
        );
    end

endmodule

// File: tb/tb_fan_pwm_ctrl.sv
// Scoreboard bench for fan_pwm_ctrl: per-period high/busy counts and tach snapshots
// are queued by the stimulus and checked by an independent monitor.
module tb_fan_pwm_ctrl;

    localparam int NCH  = 2;
    localparam int DW   = 4;
    localparam int PDIV = 2;
    localparam int KICK = 2;
    localparam int TWIN = 2;
    localparam int PER  = PDIV * (1 << DW);
    localparam int B    = PER - 1;
`ifdef FAN_PWM_CTRL_TACH_EN
    localparam int TACH_EXP = 5;
`else
    localparam int TACH_EXP = 0;
`endif

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic [NCH*DW-1:0]   duty_i;
    logic [NCH-1:0]      tach_i;
    logic [NCH-1:0]      fan_pwm_o;
    logic [NCH-1:0]      busy_o;
    logic [NCH*16-1:0]   tach_cnt_o;

    always #5 clk_i = ~clk_i;

    fan_pwm_ctrl #(
        .NumChannels (NCH),
        .DutyWidth   (DW),
        .PrescaleDiv (PDIV),
        .KickPeriods (KICK),
        .TachWindow  (TWIN)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .duty_i     (duty_i),
        .tach_i     (tach_i),
        .fan_pwm_o  (fan_pwm_o),
        .busy_o     (busy_o),
        .tach_cnt_o (tach_cnt_o)
    );

    // kind 0: statistics of one full PWM period, kind 1: outputs while in reset
    typedef struct {
        int kind;
        int h0, h1, b0, b1, t0, t1;
    } exp_t;

    exp_t sb_q[$];
    int   edge_n  = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always @(posedge clk_i) begin
        if (rst_i) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Monitor: samples every falling edge, one period = PER samples after its start edge.
    initial begin : monitor
        int   slot, per;
        int   a_h0, a_h1, a_b0, a_b1, s_t0, s_t1;
        exp_t it;
        a_h0 = 0; a_h1 = 0; a_b0 = 0; a_b1 = 0; s_t0 = 0; s_t1 = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                a_h0 = 0; a_h1 = 0; a_b0 = 0; a_b1 = 0;
                if (sb_q.size() > 0 && sb_q[0].kind == 1) begin
                    it = sb_q.pop_front();
                    check("rst_pwm", int'(fan_pwm_o), 0);
                    check("rst_busy", int'(busy_o), 0);
                    check("rst_tach_nonzero", int'(tach_cnt_o != '0), 0);
                end
            end else if (edge_n > 0) begin
                slot = (edge_n - 1) % PER;
                per  = (edge_n - 1) / PER;
                if (slot == 0) begin
                    a_h0 = 0; a_h1 = 0; a_b0 = 0; a_b1 = 0;
                    s_t0 = int'(tach_cnt_o[15:0]);
                    s_t1 = int'(tach_cnt_o[31:16]);
                end
                a_h0 += int'(fan_pwm_o[0]);
                a_h1 += int'(fan_pwm_o[1]);
                if (slot < PER - 1) begin
                    a_b0 += int'(busy_o[0]);
                    a_b1 += int'(busy_o[1]);
                end
                if (slot == PER - 1 && sb_q.size() > 0 && sb_q[0].kind == 0) begin
                    it = sb_q.pop_front();
                    check($sformatf("p%0d_pwm0_high", per), a_h0, it.h0);
                    check($sformatf("p%0d_pwm1_high", per), a_h1, it.h1);
                    check($sformatf("p%0d_busy0", per), a_b0, it.b0);
                    check($sformatf("p%0d_busy1", per), a_b1, it.b1);
                    check($sformatf("p%0d_tach0", per), s_t0, it.t0);
                    check($sformatf("p%0d_tach1", per), s_t1, it.t1);
                end
            end
        end
    end

    task automatic wait_for(input int n);
        int guard = 0;
        @(negedge clk_i);
        while (edge_n != n && guard < 5000) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 5000) check("wait_timeout", edge_n, n);
    endtask

    // Duty driven during period r (sampled at its end) and expected stats of period r.
    task automatic row(input int r, input int d0, input int d1, input int h0, input int h1,
                       input int b0, input int b1, input int t0);
        exp_t e;
        wait_for(PER * r + 1);
        #1;
        duty_i = {4'(d1), 4'(d0)};
        e = '{kind: 0, h0: h0, h1: h1, b0: b0, b1: b1, t0: t0, t1: 0};
        sb_q.push_back(e);
    endtask

    task automatic push_rst();
        exp_t e;
        e = '{kind: 1, h0: 0, h1: 0, b0: 0, b1: 0, t0: 0, t1: 0};
        sb_q.push_back(e);
    endtask

    initial begin : stimulus
        int guard;
        rst_i  = 1'b1;
        duty_i = '0;
        tach_i = '0;
        push_rst();
        repeat (3) @(negedge clk_i);
        #1 rst_i = 1'b0;

        // Idle with zero targets for 7 periods (224 cycles).
        for (int r = 0; r < 7; r++) row(r, 0, 0, 0, 0, 0, 0, 0);
        // ch0 -> 8, ch1 -> 4 from OFF: 2 kick periods, then ramp down.
        row( 7, 8, 4,  0,  0, 0, 0, 0);
        row( 8, 8, 4, 30, 30, B, B, 0);
        row( 9, 8, 4, 30, 30, B, B, 0);
        row(10, 8, 4, 30, 30, B, B, 0);
        row(11, 8, 4, 28, 28, B, B, 0);
        row(12, 8, 4, 26, 26, B, B, 0);
        row(13, 8, 4, 24, 24, B, B, 0);
        row(14, 8, 4, 22, 22, B, B, 0);
        row(15, 8, 4, 20, 20, B, B, 0);
        row(16, 8, 4, 18, 18, B, B, 0);
        row(17, 8, 4, 16, 16, 0, B, 0);
        row(18, 8, 4, 16, 14, 0, B, 0);
        row(19, 8, 4, 16, 12, 0, B, 0);
        row(20, 8, 4, 16, 10, 0, B, 0);
        row(21, 8, 4, 16,  8, 0, 0, 0);
        // ch0 target 0 from HOLD; ch1 HOLD 4 -> 6 ramps without kick.
        row(22, 0, 4, 16,  8, 0, 0, 0);
        row(23, 0, 6,  0,  8, 0, 0, 0);
        row(24, 0, 6,  0,  8, 0, B, 0);
        row(25, 0, 6,  0, 10, 0, B, 0);
        row(26, 0, 6,  0, 12, 0, 0, 0);
        row(27, 8, 0,  0, 12, 0, 0, 0);

        // Reset in the middle of ch0's first kick period.
        wait_for(PER * 28 + 10);
        #1 rst_i = 1'b1;
        push_rst();
        repeat (3) @(negedge clk_i);
        #1 rst_i = 1'b0;

        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk_i);
                    #1 tach_i[0] = 1'b1;
                    repeat (3) @(negedge clk_i);
                    #1 tach_i[0] = 1'b0;
                    repeat (2) @(negedge clk_i);
                end
            end
        join_none

        // Fresh timeline: full kick again, tach window ends every 2 periods.
        row(0, 8, 0,  0, 0, 0, 0, 0);
        row(1, 8, 0, 30, 0, B, 0, 0);
        row(2, 8, 0, 30, 0, B, 0, TACH_EXP);
        row(3, 8, 0, 30, 0, B, 0, TACH_EXP);
        row(4, 8, 0, 28, 0, B, 0, 0);

        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fan_pwm_ctrl.md
FAN_PWM_CTRL -- requirements
Module: fan_pwm_ctrl

Interface
REQ-001 SHALL have parameter NumChannels, default 2: number of independent fan channels (1..8).
REQ-002 SHALL have parameter DutyWidth, default 8: duty/PWM counter width in bits (2..12).
REQ-003 SHALL have parameter PrescaleDiv, default 50: clk_i cycles per PWM tick (>=1).
REQ-004 SHALL have parameter KickPeriods, default 4: full-duty PWM periods applied on spin-up (>=1).
REQ-005 SHALL have parameter TachWindow, default 256: PWM periods per tach measurement window.
REQ-006 SHALL have port clk_i, input, 1: single clock; one clock, all logic synchronous to it.
REQ-007 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port duty_i, input, NumChannels x DutyWidth: per-channel target duty.
REQ-009 SHALL have port tach_i, input, NumChannels: asynchronous fan tachometer pulses.
REQ-010 SHALL have port fan_pwm_o, output, NumChannels: registered PWM drive.
REQ-011 SHALL have port busy_o, output, NumChannels: channel in KICK or RAMP.
REQ-012 SHALL have port tach_cnt_o, output, NumChannels x 16: tach edges counted in last window.

Function
REQ-013 Prescaler SHALL count 0..PrescaleDiv-1 and assert a one-cycle tick on the wrap.
REQ-014 Shared PWM counter (DutyWidth bits) SHALL increment per tick and wrap from all-ones to 0; the tick causing that wrap is period end (period = PrescaleDiv*2^DutyWidth cycles).
REQ-015 fan_pwm_o[c] SHALL be registered from (pwm_cnt < cur_duty[c]): one cycle latency; duty 0 always low; duty all-ones low for exactly one tick per period.
REQ-016 Per channel FSM states OFF, KICK, RAMP, HOLD; duty_i SHALL be sampled only at period end; cur_duty changes only at period end (glitch-free).
REQ-017 OFF: cur_duty=0; at period end with sampled target!=0 -> KICK, cur_duty=all-ones, kick count cleared.
REQ-018 KICK: after KickPeriods period ends -> RAMP; cur_duty stays all-ones throughout KICK.
REQ-019 RAMP: each period end cur_duty moves by 1 toward target; when cur_duty equals target after the step -> HOLD.
REQ-020 HOLD: sampled target != cur_duty -> RAMP (no re-kick).
REQ-021 From KICK, RAMP or HOLD, sampled target 0 SHALL force OFF and cur_duty=0 at that period end (overrides other transitions).
REQ-022 Target change during KICK SHALL NOT shorten KICK; the RAMP target is the value sampled at each period end.
REQ-023 busy_o[c] SHALL be high exactly while state is KICK or RAMP.

Reset
REQ-024 On rst_i high at a clk_i edge: prescaler, PWM counter, kick and window counters = 0; all FSMs OFF; cur_duty=0; fan_pwm_o=0, busy_o=0, tach_cnt_o=0; applies mid-period and mid-KICK identically.

Configuration
REQ-025 Macro FAN_PWM_CTRL_TACH_EN: defined -> tach_i passes a 2-flop synchroniser, rising edges are counted (saturating at 16'hFFFF) per channel; every TachWindow period ends the count is copied to tach_cnt_o and cleared (an edge in the copy cycle counts into the new window).
REQ-026 Undefined -> tach_i ignored, no synchroniser/counter logic, tach_cnt_o tied 0; all other behaviour identical.

Structure
REQ-027 Package fan_pkg SHALL hold the FSM state enum (fan_state_e) and default parameter constants.
REQ-028 Sub-module fan_pwm_chan SHALL implement one channel (FSM, cur_duty, comparator, tach counter); top holds shared prescaler/PWM/window counters and generates NumChannels instances.

Verification (NumChannels=2, DutyWidth=4, PrescaleDiv=2, KickPeriods=2, TachWindow=2)
REQ-029 Reset then duty_i={0,0} for 200 cycles -> fan_pwm_o=0, busy_o=0 throughout.
REQ-030 ch0 target 8 from OFF -> 2 periods (64 cycles) high-all-but-one-tick, then ramp 15->8 over 7 periods, then HOLD with 16 high cycles of each 32; busy_o[0] falls on HOLD entry.
REQ-031 ch0 in HOLD at 8, target 0 -> fan_pwm_o[0] low from next period end +1 cycle, state OFF; ch1 unaffected.
REQ-032 ch1 HOLD at 4, target 6 -> RAMP 5, 6, HOLD; no KICK; busy_o[1] high exactly 2 periods.
REQ-033 rst_i asserted mid-KICK -> next cycle all outputs 0; after release with target 8 a fresh full KICK occurs.
REQ-034 TACH_EN: 5 tach_i pulses on ch0 in one 64-cycle window -> tach_cnt_o[0]=5 after window end; undefined build -> tach_cnt_o=0.
